// File: rtl/lfsr_arb_pkg.sv
// Shared types, default widths and helpers for the LFSR burst arbiter.
package lfsr_arb_pkg;

  // Controller phases: wait for a winner, stream bits, present the response.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WORDW = 16;
  localparam int DEF_LENW  = 5;

  // A burst can never stream more bits than the data word holds.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping around, reported both one-hot and as an index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            valid
);

  // Walk the candidates in priority order and keep the first one that asks.
  always_comb begin : search
    int              cand;
    logic [NREQ-1:0] onehot;
    grant  = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = 0;
    onehot = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand   = (int'(ptr) + k) % NREQ;
      onehot = NREQ'(1) << cand;
      if (!valid && ((req & onehot) != '0)) begin
        grant = onehot;
        idx   = IDW'(cand);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lfsr_burst_arbiter.sv
// Shares one LFSR pair between NREQ burst requesters: picks a requester
// round-robin, streams its word LSB-first into shiftBit while sampling
// outBit, then returns the collected word tagged with the requester id.
module lfsr_burst_arbiter
  import lfsr_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WORDW = DEF_WORDW,
  parameter int LENW  = DEF_LENW,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NREQ-1:0]       req__ENA,
  input  logic [NREQ*WORDW-1:0] req_data,
  input  logic [NREQ*LENW-1:0]  req_len,
  output logic [NREQ-1:0]       req__RDY,
  output logic                  rsp__ENA,
  output logic [IDW-1:0]        rsp_id,
  output logic [WORDW-1:0]      rsp_data,
  input  logic                  rsp__RDY,
  output logic                  shiftBit__ENA,
  output logic                  shiftBit_v,
  input  logic                  shiftBit__RDY,
  input  logic                  outBit,
  input  logic                  outBit__RDY
);

  localparam logic [LENW-1:0] LEN_ONE = LENW'(1);

  arb_state_t state;
  arb_state_t state_next;

  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   next_ptr;
  logic [LENW-1:0]  cnt;
  logic [WORDW-1:0] acc;
  logic [WORDW-1:0] hold_data;
  logic [LENW-1:0]  hold_len;
  logic [IDW-1:0]   hold_id;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   win_idx;
  logic             win_valid;

  logic [WORDW-1:0] sel_data;
  logic [LENW-1:0]  sel_len;
  logic [LENW-1:0]  clamped_len;
  logic [LENW-1:0]  last_idx;
  logic [WORDW-1:0] shifted_data;
  logic             cur_bit;

  logic             accept;
  logic             shift_fire;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req   (req__ENA),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win_idx),
    .valid (win_valid)
  );

  // Pick out the winner's burst, clamp its length and find the current bit.
  always_comb begin
    sel_data     = req_data[win_idx*WORDW +: WORDW];
    sel_len      = req_len[win_idx*LENW +: LENW];
    clamped_len  = LENW'(clamp_len(32'(sel_len), WORDW));
    last_idx     = hold_len - LEN_ONE;
    shifted_data = hold_data >> cnt;
    cur_bit      = shifted_data[0];
    next_ptr     = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + IDW'(1);
  end

  // Next-state and output decode; req__RDY stays low while reset is held.
  always_comb begin
    state_next    = state;
    accept        = 1'b0;
    shift_fire    = 1'b0;
    req__RDY      = '0;
    rsp__ENA      = 1'b0;
    rsp_id        = '0;
    rsp_data      = '0;
    shiftBit__ENA = 1'b0;
    shiftBit_v    = 1'b0;
    case (state)
      IDLE: begin
        if (nRST) begin
          req__RDY = grant;
        end
        accept = win_valid && ((req__ENA & req__RDY) != '0);
        if (accept) begin
          state_next = (clamped_len == '0) ? RESP : SHIFT;
        end
      end
      SHIFT: begin
        shift_fire    = shiftBit__RDY && outBit__RDY;
        shiftBit__ENA = shift_fire;
        shiftBit_v    = cur_bit;
        if (shift_fire && (cnt == last_idx)) begin
          state_next = RESP;
        end
      end
      RESP: begin
        rsp__ENA = rsp__RDY;
        rsp_id   = hold_id;
        rsp_data = acc;
        if (rsp__RDY) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; an asynchronous reset abandons any burst in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Burst holding registers, bit counter, response accumulator and rr pointer.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr    <= '0;
      cnt       <= '0;
      acc       <= '0;
      hold_data <= '0;
      hold_len  <= '0;
      hold_id   <= '0;
    end else if (accept) begin
      hold_data <= sel_data;
      hold_len  <= clamped_len;
      hold_id   <= win_idx;
      cnt       <= '0;
      acc       <= '0;
      rr_ptr    <= next_ptr;
    end else if (shift_fire) begin
      acc <= acc | (WORDW'(outBit) << cnt);
      cnt <= cnt + LEN_ONE;
    end
  end

endmodule

// File: tb/tb_lfsr_burst_arbiter.sv
// Directed bench for lfsr_burst_arbiter with a one-flop stand-in for the LFSR pair.
module tb_lfsr_burst_arbiter;

  localparam int NREQ  = 4;
  localparam int WORDW = 16;
  localparam int LENW  = 5;
  localparam int IDW   = 2;

  logic                  CLK = 1'b0;
  logic                  nRST;
  logic [NREQ-1:0]       req_ena;
  logic [NREQ*WORDW-1:0] req_data;
  logic [NREQ*LENW-1:0]  req_len;
  logic [NREQ-1:0]       req_rdy;
  logic                  rsp_ena;
  logic [IDW-1:0]        rsp_id;
  logic [WORDW-1:0]      rsp_data;
  logic                  rsp_rdy;
  logic                  shift_ena;
  logic                  shift_v;
  logic                  shift_rdy;
  logic                  out_bit;
  logic                  out_rdy;

  int checks = 0;
  int fails  = 0;
  int pulses = 0;
  int rsp_count = 0;
  int guard_viol = 0;
  logic [255:0] shist = '0;

  lfsr_burst_arbiter #(
    .NREQ  (NREQ),
    .WORDW (WORDW),
    .LENW  (LENW),
    .IDW   (IDW)
  ) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .req__ENA      (req_ena),
    .req_data      (req_data),
    .req_len       (req_len),
    .req__RDY      (req_rdy),
    .rsp__ENA      (rsp_ena),
    .rsp_id        (rsp_id),
    .rsp_data      (rsp_data),
    .rsp__RDY      (rsp_rdy),
    .shiftBit__ENA (shift_ena),
    .shiftBit_v    (shift_v),
    .shiftBit__RDY (shift_rdy),
    .outBit        (out_bit),
    .outBit__RDY   (out_rdy)
  );

  always #5 CLK = ~CLK;

  // LFSR pair stand-in: outBit is last cycle's shiftBit_v.
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) out_bit <= 1'b0;
    else       out_bit <= shift_v;
  end

  // Record shift pulses, the bits shifted, guard violations and responses.
  always @(negedge CLK) begin
    if (nRST === 1'b1) begin
      if (shift_ena === 1'b1) begin
        if (pulses < 256) shist[pulses] <= shift_v;
        pulses <= pulses + 1;
        if (!(shift_rdy && out_rdy)) guard_viol <= guard_viol + 1;
      end
      if (rsp_ena === 1'b1) rsp_count <= rsp_count + 1;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int id, input logic [WORDW-1:0] data, input logic [LENW-1:0] len);
    req_data[id*WORDW +: WORDW] = data;
    req_len[id*LENW +: LENW]    = len;
    req_ena[id]                 = 1'b1;
  endtask

  task automatic do_reset();
    nRST      = 1'b0;
    req_ena   = '0;
    req_data  = '0;
    req_len   = '0;
    rsp_rdy   = 1'b1;
    shift_rdy = 1'b1;
    out_rdy   = 1'b1;
    repeat (2) tick();
    nRST = 1'b1;
  endtask

  task automatic wait_rsp(input string tag, output int cycles);
    cycles = 0;
    while (rsp_ena !== 1'b1 && cycles < 60) begin
      tick();
      cycles++;
    end
    check_output({tag, "_rsp_seen"}, 32'(rsp_ena), 1);
  endtask

  initial begin : stimulus
    int cyc;
    int base;
    int rsp_base;
    logic [15:0] got;
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};

    // Reset state
    nRST = 1'b0; req_ena = '0; req_data = '0; req_len = '0;
    rsp_rdy = 1'b1; shift_rdy = 1'b1; out_rdy = 1'b1;
    #1;
    check_output("rst_req_rdy", 32'(req_rdy), 0);
    check_output("rst_rsp_ena", 32'(rsp_ena), 0);
    check_output("rst_shift_ena", 32'(shift_ena), 0);
    check_output("rst_rsp_id", 32'(rsp_id), 0);
    check_output("rst_rsp_data", 32'(rsp_data), 0);

    // Single burst: requester 1, 0x00B5, 8 bits
    do_reset();
    apply_stimulus(1, 16'h00B5, 5'd8);
    #1;
    base = pulses;
    check_output("t1_grant", 32'(req_rdy), 32'b0010);
    wait_rsp("t1", cyc);
    req_ena = '0;
    check_output("t1_latency", cyc, 9);
    check_output("t1_rsp_id", 32'(rsp_id), 1);
    check_output("t1_rsp_data", 32'(rsp_data), 32'h006A);
    check_output("t1_pulses", pulses - base, 8);
    got = '0;
    for (int k = 0; k < 8; k++) got[k] = shist[base + k];
    check_output("t1_shift_seq", 32'(got), 32'h00B5);
    tick();
    check_output("t1_idle_rsp_ena", 32'(rsp_ena), 0);

    // Round-robin with all four requesters held active
    do_reset();
    for (int i = 0; i < NREQ; i++) apply_stimulus(i, WORDW'(i), 5'd2);
    #1;
    for (int b = 0; b < 5; b++) begin
      check_output("t2_grant", 32'(req_rdy), 32'(1) << exp_order[b]);
      wait_rsp("t2", cyc);
      check_output("t2_latency", cyc, 3);
      check_output("t2_rsp_id", 32'(rsp_id), exp_order[b]);
      check_output("t2_rsp_data", 32'(rsp_data), (exp_order[b] & 1) << 1);
      tick();
    end
    req_ena = '0;

    // Stall mid-burst on both guards
    do_reset();
    apply_stimulus(0, 16'hFFFF, 5'd16);
    #1;
    base = pulses;
    check_output("t3_grant", 32'(req_rdy), 32'b0001);
    tick();
    req_ena = '0;
    repeat (4) tick();
    shift_rdy = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      check_output("t3_stall_ena", 32'(shift_ena), 0);
      tick();
    end
    shift_rdy = 1'b1;
    out_rdy   = 1'b0;
    #1;
    check_output("t3_outrdy_stall_ena", 32'(shift_ena), 0);
    tick();
    out_rdy = 1'b1;
    wait_rsp("t3", cyc);
    check_output("t3_pulses", pulses - base, 16);
    check_output("t3_guard_viol", guard_viol, 0);
    check_output("t3_rsp_id", 32'(rsp_id), 0);
    check_output("t3_rsp_data", 32'(rsp_data), 32'hFFFE);
    tick();

    // len = 0: immediate zero response
    do_reset();
    apply_stimulus(3, 16'hABCD, 5'd0);
    #1;
    base = pulses;
    check_output("t4_grant", 32'(req_rdy), 32'b1000);
    wait_rsp("t4", cyc);
    req_ena = '0;
    check_output("t4_latency", cyc, 1);
    check_output("t4_rsp_id", 32'(rsp_id), 3);
    check_output("t4_rsp_data", 32'(rsp_data), 0);
    check_output("t4_pulses", pulses - base, 0);
    tick();

    // len = 31 clamps to 16 shifts; pointer wrapped back to 0 after requester 3
    apply_stimulus(2, 16'h1234, 5'd31);
    #1;
    base = pulses;
    check_output("t5_grant", 32'(req_rdy), 32'b0100);
    wait_rsp("t5", cyc);
    req_ena = '0;
    check_output("t5_latency", cyc, 17);
    check_output("t5_pulses", pulses - base, 16);
    check_output("t5_rsp_id", 32'(rsp_id), 2);
    check_output("t5_rsp_data", 32'(rsp_data), 32'h2468);
    tick();

    // Response back-pressure with another requester waiting
    do_reset();
    rsp_rdy = 1'b0;
    apply_stimulus(0, 16'h000F, 5'd4);
    apply_stimulus(2, 16'h0003, 5'd2);
    #1;
    check_output("t6_grant", 32'(req_rdy), 32'b0001);
    tick();
    repeat (4) tick();
    for (int s = 0; s < 5; s++) begin
      check_output("t6_hold_rsp_ena", 32'(rsp_ena), 0);
      check_output("t6_hold_rsp_data", 32'(rsp_data), 32'h000E);
      check_output("t6_hold_rsp_id", 32'(rsp_id), 0);
      check_output("t6_hold_req_rdy", 32'(req_rdy), 0);
      tick();
    end
    rsp_rdy = 1'b1;
    #1;
    check_output("t6_rsp_ena", 32'(rsp_ena), 1);
    tick();
    check_output("t6_next_grant", 32'(req_rdy), 32'b0100);
    req_ena = '0;
    tick();

    // Reset during shift 4 of an 8-bit burst
    do_reset();
    apply_stimulus(0, 16'h00B5, 5'd8);
    #1;
    tick();
    req_ena = '0;
    repeat (3) tick();
    check_output("t7_pre_shift_ena", 32'(shift_ena), 1);
    rsp_base = rsp_count;
    base     = pulses;
    nRST = 1'b0;
    #1;
    check_output("t7_rst_shift_ena", 32'(shift_ena), 0);
    check_output("t7_rst_rsp_ena", 32'(rsp_ena), 0);
    check_output("t7_rst_req_rdy", 32'(req_rdy), 0);
    check_output("t7_rst_rsp_id", 32'(rsp_id), 0);
    check_output("t7_rst_rsp_data", 32'(rsp_data), 0);
    repeat (3) tick();
    nRST = 1'b1;
    apply_stimulus(2, 16'h0003, 5'd2);
    #1;
    check_output("t7_grant", 32'(req_rdy), 32'b0100);
    wait_rsp("t7", cyc);
    req_ena = '0;
    check_output("t7_latency", cyc, 3);
    check_output("t7_rsp_id", 32'(rsp_id), 2);
    check_output("t7_rsp_data", 32'(rsp_data), 32'h0002);
    tick();
    check_output("t7_rsp_count", rsp_count - rsp_base, 1);
    check_output("t7_pulses", pulses - base, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
